// File: rtl/flash_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// flash_boot_pkg
// Shared definitions for the flash boot loader:
//   - state_t         : copy FSM state enumeration
//   - FLASH_DAT_OFS   : offset of the flash slave data register
//   - FLASH_ADR_OFS   : offset of the flash slave byte-address register
//   - TIMEOUT_DEFAULT : default bus watchdog limit in cycles
//   - bus_req_t       : the address/data/strobe/direction set of one bus cycle
//   - is_bus_state()  : true for the states that run a Wishbone cycle
// -----------------------------------------------------------------------------
package flash_boot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_ADR = 3'd1,
        RD_DAT  = 3'd2,
        WR_RAM  = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [31:0] FLASH_DAT_OFS   = 32'h0000_0000;
    localparam logic [31:0] FLASH_ADR_OFS   = 32'h0000_0004;
    localparam int          TIMEOUT_DEFAULT = 255;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } bus_req_t;

    function automatic logic is_bus_state(input state_t s);
        return (s == SET_ADR) || (s == RD_DAT) || (s == WR_RAM);
    endfunction

endpackage

// File: rtl/flash_boot_loader_if.sv
// -----------------------------------------------------------------------------
// flash_boot_loader_if
// Wishbone classic bus between the boot loader (master) and the flash/RAM
// fabric (slave).
//   adr_o[31:0], dat_o[31:0], sel_o[3:0], we_o, cyc_o, stb_o : master -> slave
//   dat_i[31:0], ack_i, err_i, rty_i                         : slave  -> master
// -----------------------------------------------------------------------------
interface flash_boot_loader_if;

    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    modport master (
        output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        output dat_i, ack_i, err_i, rty_i
    );

endinterface

// File: rtl/flash_boot_loader_watchdog.sv
// -----------------------------------------------------------------------------
// bus_watchdog
// Counts cycles in which a bus cycle is outstanding and flags expiry on the
// TIMEOUT-th such cycle, so the strobe is held for exactly TIMEOUT cycles.
//   clk_bus : clock (rising edge)
//   rst_bus : asynchronous active-low reset
//   clear   : restart the count (held while no cycle is outstanding)
//   active  : a bus cycle is outstanding this cycle
//   expired : combinational, high in the TIMEOUT-th active cycle
// -----------------------------------------------------------------------------
module bus_watchdog
    import flash_boot_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_bus,
    input  logic rst_bus,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (active && !expired) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // The count equals the number of active cycles already elapsed, so the
    // TIMEOUT-th active cycle sees TIMEOUT-1.
    assign expired = active && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/flash_boot_loader.sv
// -----------------------------------------------------------------------------
// flash_boot_loader
// Copies word_count 32-bit words from a byte-wide flash slave into RAM over a
// Wishbone classic master. Every flash byte costs two bus cycles: a write of
// the byte pointer to the flash address register, then a read of the data
// register. Four bytes are assembled little-endian and written to RAM.
//
// Ports
//   clk_bus     : clock (rising edge)
//   rst_bus     : asynchronous active-low reset
//   start       : one-cycle copy request, accepted only when idle
//   src_addr    : flash byte address of the first byte (23 bits)
//   dst_addr    : RAM byte address of the first word
//   word_count  : number of words to copy (0 completes immediately)
//   busy        : high in every state but IDLE
//   done        : one-cycle pulse at the end of a copy (success or error)
//   error       : sticky error flag, cleared by the next accepted start
//   words_done  : number of words written to RAM so far
//   wb          : Wishbone master
// -----------------------------------------------------------------------------
module flash_boot_loader
    import flash_boot_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE = 32'h1000_0000,
    parameter int          TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic        clk_bus,
    input  logic        rst_bus,
    input  logic        start,
    input  logic [22:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_done,
    flash_boot_loader_if.master wb
);

    state_t      state_reg, state_next, target;
    logic        gap_reg, gap_next;
    bus_req_t    req_reg, req_next;
    logic [22:0] byte_ptr_reg, byte_ptr_next;
    logic [31:0] dst_ptr_reg, dst_ptr_next;
    logic [15:0] words_done_reg, words_done_next;
    logic [15:0] word_count_reg, word_count_next;
    logic        error_reg, error_next;

    logic        bus_active;
    logic        wd_expired;
    logic        start_accept;
    logic        capture;
    logic [31:0] word_asm;

    // A bus state runs its cycle until a response is sampled, then spends one
    // more cycle in the same state with the strobe low (gap_reg). That keeps
    // the strobe asserted from state entry and guarantees an idle cycle
    // between consecutive bus cycles.
    assign bus_active   = is_bus_state(state_reg) && !gap_reg;
    assign start_accept = (state_reg == IDLE) && start;
    assign capture      = (state_reg == RD_DAT) && bus_active && wb.ack_i
                          && !wb.err_i && !wb.rty_i;

    // Address, data, lanes and direction for the cycle run in state s.
    function automatic bus_req_t make_req(input state_t      s,
                                          input logic [22:0] bp,
                                          input logic [31:0] dp,
                                          input logic [31:0] w);
        bus_req_t r;
        r = '0;
        case (s)
            SET_ADR: begin
                r.adr = FLASH_BASE + FLASH_ADR_OFS;
                r.dat = {9'b0, bp};
                r.sel = 4'hF;
                r.we  = 1'b1;
            end
            RD_DAT: begin
                r.adr = FLASH_BASE + FLASH_DAT_OFS;
                r.sel = 4'hF;
                r.we  = 1'b0;
            end
            WR_RAM: begin
                r.adr = dp;
                r.dat = w;
                r.sel = 4'hF;
                r.we  = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Byte assembly: lane k is loaded when the byte with pointer[1:0]==k is
    // read, and all lanes clear when a new copy starts.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk_bus or negedge rst_bus) begin
                if (!rst_bus) begin
                    lane_reg <= '0;
                end else if (start_accept) begin
                    lane_reg <= '0;
                end else if (capture && (byte_ptr_reg[1:0] == 2'(gi))) begin
                    lane_reg <= wb.dat_i[7:0];
                end
            end
            assign word_asm[8*gi +: 8] = lane_reg;
        end
    endgenerate

    // Counter is held at zero whenever no cycle is outstanding, so each new
    // bus cycle starts counting from zero.
    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_bus (clk_bus),
        .rst_bus (rst_bus),
        .clear   (!bus_active),
        .active  (bus_active),
        .expired (wd_expired)
    );

    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            state_reg      <= IDLE;
            gap_reg        <= 1'b0;
            req_reg        <= '0;
            byte_ptr_reg   <= '0;
            dst_ptr_reg    <= '0;
            words_done_reg <= '0;
            word_count_reg <= '0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gap_reg        <= gap_next;
            req_reg        <= req_next;
            byte_ptr_reg   <= byte_ptr_next;
            dst_ptr_reg    <= dst_ptr_next;
            words_done_reg <= words_done_next;
            word_count_reg <= word_count_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        target          = state_reg;
        gap_next        = gap_reg;
        req_next        = req_reg;
        byte_ptr_next   = byte_ptr_reg;
        dst_ptr_next    = dst_ptr_reg;
        words_done_next = words_done_reg;
        word_count_next = word_count_reg;
        error_next      = error_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    byte_ptr_next   = src_addr;
                    dst_ptr_next    = dst_addr;
                    word_count_next = word_count;
                    words_done_next = '0;
                    error_next      = 1'b0;
                    gap_next        = 1'b0;
                    if (word_count == 16'd0) begin
                        state_next = DONE;
                        req_next   = '0;
                    end else begin
                        state_next = SET_ADR;
                        req_next   = make_req(SET_ADR, src_addr, dst_addr, 32'd0);
                    end
                end
            end

            SET_ADR, RD_DAT, WR_RAM: begin
                if (!gap_reg) begin
                    // err/rty win over a simultaneous ack; ack wins over a
                    // watchdog expiry landing in the same cycle.
                    if (wb.err_i || wb.rty_i || (!wb.ack_i && wd_expired)) begin
                        state_next = ERR;
                        error_next = 1'b1;
                        req_next   = '0;
                    end else if (wb.ack_i) begin
                        gap_next = 1'b1;
                        if (state_reg == RD_DAT) begin
                            byte_ptr_next = byte_ptr_reg + 23'd1;
                        end else if (state_reg == WR_RAM) begin
                            dst_ptr_next    = dst_ptr_reg + 32'd4;
                            words_done_next = words_done_reg + 16'd1;
                        end
                    end
                end else begin
                    // Pointers and counters were already advanced on the ack,
                    // so the decision uses their updated values.
                    gap_next = 1'b0;
                    if (state_reg == SET_ADR) begin
                        target = RD_DAT;
                    end else if (state_reg == RD_DAT) begin
                        target = (byte_ptr_reg[1:0] == 2'd0) ? WR_RAM : SET_ADR;
                    end else begin
                        target = (words_done_reg == word_count_reg) ? DONE : SET_ADR;
                    end
                    state_next = target;
                    req_next   = make_req(target, byte_ptr_reg, dst_ptr_reg, word_asm);
                end
            end

            DONE, ERR: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wb.cyc_o   = bus_active;
    assign wb.stb_o   = bus_active;
    assign wb.adr_o   = req_reg.adr;
    assign wb.dat_o   = req_reg.dat;
    assign wb.sel_o   = req_reg.sel;
    assign wb.we_o    = req_reg.we;

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE) || (state_reg == ERR);
    assign error      = error_reg;
    assign words_done = words_done_reg;

endmodule

// File: tb/tb_flash_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_flash_boot_loader
// Bench for flash_boot_loader: a behavioural flash/RAM slave with
// configurable latency and fault injection, a table of directed copies, a
// randomized batch checked against a word-level copy model, and hand-written
// sequences for reset, zero-length and restart corner cases.
// -----------------------------------------------------------------------------
module tb_flash_boot_loader;

    localparam logic [31:0] FB = 32'h1000_0000;

    logic        clk_bus = 1'b0;
    logic        rst_bus = 1'b1;
    logic        start = 1'b0;
    logic [22:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error;
    logic [15:0] words_done;

    flash_boot_loader_if wb();

    flash_boot_loader #(
        .FLASH_BASE (FB),
        .TIMEOUT    (255)
    ) dut (
        .clk_bus    (clk_bus),
        .rst_bus    (rst_bus),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .wb         (wb)
    );

    always #5 clk_bus = ~clk_bus;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, want %0h", tag, name, act, exp);
        end
    endtask

    // Flash contents as a pure function of the byte address.
    function automatic logic [7:0] flash_byte(input logic [22:0] a);
        logic [7:0] t;
        t = a[7:0] + 8'd1;
        t = t * 8'h11;
        return t ^ {1'b0, a[22:16]};
    endfunction

    // Expected RAM word w of a copy from an aligned flash source.
    function automatic logic [31:0] model_word(input logic [22:0] src, input int w);
        logic [31:0] r;
        logic [22:0] a;
        for (int b = 0; b < 4; b++) begin
            a = src + 23'(4 * w + b);
            r[8*b +: 8] = flash_byte(a);
        end
        return r;
    endfunction

    // ---------------- slave + monitor ----------------
    int cfg_lat = 0, cfg_err_at = 0, cfg_hang = 0;
    int wait_cnt = 0, rd_idx = 0, flash_cyc = 0, ram_wr = 0, cyc_starts = 0;
    int done_cnt = 0, busy_cyc = 0, stb_run = 0, stb_run_max = 0;
    logic [22:0] flash_ptr = '0;
    logic [31:0] ram [logic [31:0]];
    logic        prev_stb = 1'b0, prev_resp = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_adr = '0, prev_dat = '0;
    logic [3:0]  prev_sel = '0;

    task automatic clear_tallies();
        rd_idx = 0; flash_cyc = 0; ram_wr = 0; cyc_starts = 0;
        done_cnt = 0; busy_cyc = 0; stb_run_max = 0;
        ram.delete();
    endtask

    initial begin
        logic        is_flash, hold;
        logic [31:0] junk;
        wb.dat_i = '0; wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.rty_i = 1'b0;
        forever begin
            @(negedge clk_bus);
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            if (prev_resp) check("bus", "idle_after_resp", 64'(wb.stb_o), 64'd0);
            if (wb.stb_o && prev_stb) begin
                check("bus", "stable_adr_dat", {wb.adr_o, wb.dat_o}, {prev_adr, prev_dat});
                check("bus", "stable_sel_we", {wb.sel_o, wb.we_o}, {prev_sel, prev_we});
            end
            is_flash = (wb.adr_o == FB) || (wb.adr_o == FB + 32'd4);
            if (wb.stb_o && !prev_stb) begin
                cyc_starts++;
                if (is_flash) flash_cyc++;
                wait_cnt = 0;
            end
            prev_resp = 1'b0;
            if (!wb.stb_o) begin
                wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.rty_i = 1'b0;
                stb_run = 0;
            end else begin
                stb_run++;
                if (stb_run > stb_run_max) stb_run_max = stb_run;
                wait_cnt++;
                hold = (cfg_hang == 1 && wb.adr_o == FB + 32'd4) ||
                       (cfg_hang == 2 && wb.we_o && !is_flash);
                if (!hold && wait_cnt > cfg_lat) begin
                    prev_resp = 1'b1;
                    if (wb.we_o) check("bus", "sel_on_write", 64'(wb.sel_o), 64'hF);
                    if (wb.adr_o == FB + 32'd4 && wb.we_o) begin
                        flash_ptr = wb.dat_o[22:0];
                        wb.ack_i = 1'b1;
                    end else if (wb.adr_o == FB && !wb.we_o) begin
                        rd_idx++;
                        if (rd_idx == cfg_err_at) begin
                            wb.err_i = 1'b1;
                        end else begin
                            junk = $urandom();
                            wb.dat_i = {junk[31:8], flash_byte(flash_ptr)};
                            wb.ack_i = 1'b1;
                        end
                    end else if (wb.we_o) begin
                        ram[wb.adr_o] = wb.dat_o;
                        ram_wr++;
                        wb.ack_i = 1'b1;
                    end else begin
                        wb.ack_i = 1'b1;
                    end
                end else begin
                    wb.ack_i = 1'b0; wb.err_i = 1'b0;
                end
            end
            prev_stb = wb.stb_o; prev_adr = wb.adr_o; prev_dat = wb.dat_o;
            prev_sel = wb.sel_o; prev_we = wb.we_o;
        end
    end

    // ---------------- copy runner ----------------
    typedef struct {
        logic [22:0] src;
        logic [31:0] dst;
        logic [15:0] cnt;
        int          lat;
        int          err_at;
        int          hang;
        int          restart;
        logic        exp_err;
        int          exp_words;
        int          exp_flash;
        int          exp_ram;
    } vec_t;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 32'hDEAD_BEEF;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int t;
        clear_tallies();
        cfg_lat = v.lat; cfg_err_at = v.err_at; cfg_hang = v.hang;
        @(negedge clk_bus);
        src_addr = v.src; dst_addr = v.dst; word_count = v.cnt; start = 1'b1;
        @(negedge clk_bus);
        start = 1'b0;
        if (v.restart > 0) begin
            repeat (v.restart - 1) @(negedge clk_bus);
            src_addr = 23'h7000; dst_addr = 32'h9000; word_count = 16'd7; start = 1'b1;
            @(negedge clk_bus);
            start = 1'b0;
        end
        t = 0;
        while (!done && t < 4000) begin
            @(negedge clk_bus);
            t++;
        end
        check(tag, "done_seen", 64'(done), 64'd1);
        repeat (4) @(negedge clk_bus);
        check(tag, "done_once", 64'(done_cnt), 64'd1);
        check(tag, "error", 64'(error), 64'(v.exp_err));
        check(tag, "words_done", 64'(words_done), 64'(v.exp_words));
        check(tag, "flash_cycles", 64'(flash_cyc), 64'(v.exp_flash));
        check(tag, "ram_writes", 64'(ram_wr), 64'(v.exp_ram));
        check(tag, "busy_after", 64'(busy), 64'd0);
        for (int w = 0; w < v.exp_ram; w++)
            check(tag, $sformatf("ram_w%0d", w), 64'(ram_rd(v.dst + 32'(4 * w))),
                  64'(model_word(v.src, w)));
        if (v.hang == 1) check(tag, "stb_hold_cycles", 64'(stb_run_max), 64'd255);
        $display("%s src=%06h dst=%08h cnt=%0d lat=%0d -> words_done=%0d error=%0d flash=%0d ram=%0d",
                 tag, v.src, v.dst, v.cnt, v.lat, words_done, error, flash_cyc, ram_wr);
        cfg_hang = 0; cfg_err_at = 0; cfg_lat = 0;
    endtask

    vec_t vecs[7];

    initial begin
        vec_t v;
        logic [31:0] rv;
        int t;

        //              src          dst           cnt lat err hang rst  err words fl  ram
        vecs[0] = '{23'h000100, 32'h8000_0000, 16'd2, 0, 0, 0, 0, 1'b0, 2, 16, 2};
        vecs[1] = '{23'h000040, 32'h8000_1000, 16'd0, 0, 0, 0, 0, 1'b0, 0, 0, 0};
        vecs[2] = '{23'h000200, 32'h0000_1000, 16'd1, 0, 3, 0, 0, 1'b1, 0, 6, 0};
        vecs[3] = '{23'h000300, 32'h0000_2000, 16'd1, 0, 0, 1, 0, 1'b1, 0, 1, 0};
        vecs[4] = '{23'h7FFFF8, 32'hFFFF_FFF8, 16'd4, 1, 0, 0, 0, 1'b0, 4, 32, 4};
        vecs[5] = '{23'h000040, 32'h0000_2000, 16'd2, 2, 0, 0, 5, 1'b0, 2, 16, 2};
        vecs[6] = '{23'h000500, 32'h0000_3000, 16'd3, 0, 8, 0, 0, 1'b1, 1, 16, 1};

        // Reset state, then a zero-length start on the first edge after release.
        #2 rst_bus = 1'b0;
        repeat (3) @(negedge clk_bus);
        check("reset", "busy", 64'(busy), 64'd0);
        check("reset", "done", 64'(done), 64'd0);
        check("reset", "error", 64'(error), 64'd0);
        check("reset", "words_done", 64'(words_done), 64'd0);
        check("reset", "cyc_stb_we", {wb.cyc_o, wb.stb_o, wb.we_o}, 64'd0);
        check("reset", "adr_dat_sel", {wb.adr_o, wb.dat_o} ^ 64'(wb.sel_o), 64'd0);
        clear_tallies();
        rst_bus = 1'b1; word_count = 16'd0; start = 1'b1;
        @(negedge clk_bus);
        start = 1'b0;
        check("zero", "done_next_cycle", 64'(done), 64'd1);
        check("zero", "busy_next_cycle", 64'(busy), 64'd1);
        @(negedge clk_bus);
        check("zero", "done_drops", 64'(done), 64'd0);
        @(negedge clk_bus);
        check("zero", "busy_cycles", 64'(busy_cyc), 64'd1);
        check("zero", "done_pulses", 64'(done_cnt), 64'd1);
        check("zero", "no_bus_cycle", 64'(cyc_starts), 64'd0);
        $display("zero: busy_cycles=%0d done_pulses=%0d bus_cycles=%0d", busy_cyc, done_cnt, cyc_starts);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                check("vec0", "ram_word0_const", 64'(ram_rd(32'h8000_0000)), 64'h4433_2211);
                check("vec0", "ram_word1_const", 64'(ram_rd(32'h8000_0004)), 64'h8877_6655);
            end
        end

        // Reset in the middle of a RAM write with the strobe up.
        clear_tallies();
        cfg_hang = 2;
        @(negedge clk_bus);
        src_addr = 23'h000300; dst_addr = 32'h0000_5000; word_count = 16'd1; start = 1'b1;
        @(negedge clk_bus);
        start = 1'b0;
        t = 0;
        while (!(wb.stb_o && wb.we_o && wb.adr_o == 32'h0000_5000) && t < 1000) begin
            @(negedge clk_bus);
            t++;
        end
        check("rstmid", "reached_wr_ram", 64'(wb.stb_o), 64'd1);
        #2 rst_bus = 1'b0;
        #1;
        check("rstmid", "cyc_async", 64'(wb.cyc_o), 64'd0);
        check("rstmid", "stb_we_async", {wb.stb_o, wb.we_o}, 64'd0);
        check("rstmid", "busy_async", 64'(busy), 64'd0);
        check("rstmid", "words_done_async", 64'(words_done), 64'd0);
        check("rstmid", "adr_async", 64'(wb.adr_o), 64'd0);
        $display("rstmid: cyc=%0d busy=%0d words_done=%0d", wb.cyc_o, busy, words_done);
        @(negedge clk_bus);
        rst_bus = 1'b1;
        cfg_hang = 0;
        v = '{23'h000300, 32'h0000_5000, 16'd1, 0, 0, 0, 0, 1'b0, 1, 8, 1};
        run_vec(v, "after_rst");

        // Randomized copies against the word-level model.
        for (int r = 0; r < 16; r++) begin
            rv = $urandom();
            v.src = rv[22:0] & 23'h7FFFFC;
            rv = $urandom();
            v.dst = {4'h8, rv[27:2], 2'b00};
            v.cnt = 16'($urandom_range(1, 4));
            v.lat = $urandom_range(0, 3);
            v.err_at = 0; v.hang = 0; v.restart = 0;
            v.exp_err = 1'b0;
            v.exp_words = int'(v.cnt);
            v.exp_flash = 8 * int'(v.cnt);
            v.exp_ram = int'(v.cnt);
            run_vec(v, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
